// File: rtl/fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// fetch_stage_pkg
// Shared CPU definitions used by the fetch stage and the pipeline registers:
//   PC_W / INSTR_W  - word-addressed PC width and instruction width
//   NOP             - bubble instruction written into pipeline registers
//   fetchStateT     - fetch sequencer states
//   jTypeT          - jump classification produced upstream; the hazard
//                     logic turns a taken jump of any of these into flush
//   pcInc()         - PC increment, wrapping modulo 2^PC_W
// ---------------------------------------------------------------------------
package fetch_stage_pkg;

    localparam int PC_W    = 12;
    localparam int INSTR_W = 16;
    localparam logic [INSTR_W-1:0] NOP = 16'h0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // idle, may issue a request
        WAIT  = 2'd1,   // one request outstanding
        HOLD  = 2'd2    // response captured, decode stalled
    } fetchStateT;

    typedef enum logic [2:0] {
        J_NONE = 3'd0,
        J_JAL  = 3'd1,
        J_JR   = 3'd2,
        J_BEQ  = 3'd3,
        J_BNE  = 3'd4
    } jTypeT;

    function automatic logic [PC_W-1:0] pcInc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Instruction-memory request/response channel.
//   imReq   - one-cycle request strobe         (master -> slave)
//   imAddr  - request word address             (master -> slave)
//   imValid - response strobe                  (slave -> master)
//   imData  - response instruction             (slave -> master)
// Only one request may be outstanding; the response comes at least one
// cycle after its request.
// ---------------------------------------------------------------------------
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic               imReq;
    logic [PC_W-1:0]    imAddr;
    logic               imValid;
    logic [INSTR_W-1:0] imData;

    modport master (output imReq, output imAddr, input imValid, input imData);
    modport slave  (input imReq, input imAddr, output imValid, output imData);

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// Generic pipeline register (instruction, link PC, valid) with hold/squash.
//   clk, rstN            - clock, asynchronous active-low reset
//   hold                 - keep contents; overrides squash and load
//   squash               - load a bubble {BUBBLE, 0, valid=0}
//   load                 - capture {instrIn, pcIn, valid=1}
//   instrOut/pcOut/validOut - registered contents
// With none of hold/squash/load asserted the contents are kept.
// ---------------------------------------------------------------------------
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int              IW     = INSTR_W,
    parameter int              PW     = PC_W,
    parameter logic [IW-1:0]   BUBBLE = NOP
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          hold,
    input  logic          squash,
    input  logic          load,
    input  logic [IW-1:0] instrIn,
    input  logic [PW-1:0] pcIn,
    output logic [IW-1:0] instrOut,
    output logic [PW-1:0] pcOut,
    output logic          validOut
);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            instrOut <= BUBBLE;
            pcOut    <= '0;
            validOut <= 1'b0;
        end else if (!hold) begin
            if (squash) begin
                instrOut <= BUBBLE;
                pcOut    <= '0;
                validOut <= 1'b0;
            end else if (load) begin
                instrOut <= instrIn;
                pcOut    <= pcIn;
                validOut <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction fetch with single-outstanding memory requests and the IF/ID
// pipeline register.
//   clk, rstN        - clock, asynchronous active-low reset
//   stallPC          - do not issue a new request this cycle
//   stallID          - hold IF/ID; do not accept a new instruction
//   flush, jTarget   - squash IF/ID and redirect fetch to jTarget
//   im (master)      - instruction-memory channel (imReq/imAddr/imValid/imData)
//   instrID, pcID, validID - IF/ID contents (pcID is the link value addr+1)
// A flush that lands while a request is outstanding sets a drop flag so
// the stale response is discarded when it arrives.
// ---------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rstN,
    input  logic               stallPC,
    input  logic               stallID,
    input  logic               flush,
    input  logic [PC_W-1:0]    jTarget,
    fetch_stage_if.master      im,
    output logic [INSTR_W-1:0] instrID,
    output logic [PC_W-1:0]    pcID,
    output logic               validID
);

    fetchStateT         stateReg, stateNext;
    logic [PC_W-1:0]    pcReg, pcNext;
    logic               dropReg, dropNext;
    logic [INSTR_W-1:0] holdBufReg, holdBufNext;

    logic               reqNow;
    logic               squashId;
    logic               loadId;
    logic [INSTR_W-1:0] loadInstr;
    logic [PC_W-1:0]    linkPc;

    assign linkPc = pcInc(pcReg);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            stateReg   <= FETCH;
            pcReg      <= '0;
            dropReg    <= 1'b0;
            holdBufReg <= '0;
        end else begin
            stateReg   <= stateNext;
            pcReg      <= pcNext;
            dropReg    <= dropNext;
            holdBufReg <= holdBufNext;
        end
    end

    always_comb begin
        stateNext   = stateReg;
        pcNext      = pcReg;
        dropNext    = dropReg;
        holdBufNext = holdBufReg;
        reqNow      = 1'b0;
        loadId      = 1'b0;
        loadInstr   = im.imData;
        // A stalled decode stage swallows the flush entirely.
        squashId    = flush & ~stallID;

        if (squashId) begin
            pcNext      = jTarget;
            holdBufNext = '0;
        end

        unique case (stateReg)
            FETCH: begin
                reqNow = ~stallPC & ~flush;
                if (reqNow) begin
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                if (im.imValid) begin
                    if (squashId || dropReg) begin
                        // Response belongs to the abandoned path.
                        dropNext  = 1'b0;
                        stateNext = FETCH;
                    end else if (!stallID) begin
                        loadId    = 1'b1;
                        pcNext    = linkPc;
                        stateNext = FETCH;
                    end else begin
                        holdBufNext = im.imData;
                        stateNext   = HOLD;
                    end
                end else if (squashId) begin
                    // Keep waiting so the in-flight response is consumed,
                    // but remember to throw it away.
                    dropNext = 1'b1;
                end
            end
            HOLD: begin
                if (squashId) begin
                    stateNext = FETCH;
                end else if (!stallID) begin
                    loadId    = 1'b1;
                    loadInstr = holdBufReg;
                    pcNext    = linkPc;
                    stateNext = FETCH;
                end
            end
            default: begin
                stateNext = FETCH;
            end
        endcase
    end

    assign im.imReq  = reqNow;
    assign im.imAddr = pcReg;

    if_id_reg #(
        .IW     (INSTR_W),
        .PW     (PC_W),
        .BUBBLE (NOP)
    ) ifIdReg (
        .clk      (clk),
        .rstN     (rstN),
        .hold     (stallID),
        .squash   (squashId),
        .load     (loadId),
        .instrIn  (loadInstr),
        .pcIn     (linkPc),
        .instrOut (instrID),
        .pcOut    (pcID),
        .validOut (validID)
    );

endmodule
